// File: rtl/load_store_queue_pkg.sv
// Shared encodings for the load/store queue: memory op codes, MMIO boundary
// and the per-cycle action selector.
package load_store_queue_pkg;

    localparam int INST_OP_WIDTH = 4;

    localparam logic [INST_OP_WIDTH-1:0] OP_LB  = 4'h0;
    localparam logic [INST_OP_WIDTH-1:0] OP_LH  = 4'h1;
    localparam logic [INST_OP_WIDTH-1:0] OP_LW  = 4'h2;
    localparam logic [INST_OP_WIDTH-1:0] OP_LBU = 4'h3;
    localparam logic [INST_OP_WIDTH-1:0] OP_LHU = 4'h4;
    localparam logic [INST_OP_WIDTH-1:0] OP_SB  = 4'h5;
    localparam logic [INST_OP_WIDTH-1:0] OP_SH  = 4'h6;
    localparam logic [INST_OP_WIDTH-1:0] OP_SW  = 4'h7;

    localparam logic [31:0] MMIO_BASE_DEFAULT = 32'h0003_0000;

    typedef enum logic [1:0] {
        ACT_NONE,
        ACT_STORE,
        ACT_LOAD,
        ACT_FWD
    } lsq_act_e;

    function automatic logic op_is_store(input logic [INST_OP_WIDTH-1:0] op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/lsq_oldest_picker.sv
// Circular priority select: first set request bit at or after i_head,
// wrapping modulo DEPTH.
module lsq_oldest_picker #(
    parameter int DEPTH = 16,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0] i_req,
    input  logic [PTR_W-1:0] i_head,
    output logic             o_valid,
    output logic [PTR_W-1:0] o_idx
);

    always_comb begin
        o_valid = 1'b0;
        o_idx   = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (!o_valid && i_req[i_head + PTR_W'(k)]) begin
                o_valid = 1'b1;
                o_idx   = i_head + PTR_W'(k);
            end
        end
    end

endmodule

// File: rtl/load_store_queue.sv
// Load/store queue: out-of-order load issue past disjoint older stores,
// SW->LW forwarding, and in-order committed store drain.
module load_store_queue
    import load_store_queue_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int NUM_CDB = 2,
    parameter int XLEN    = 32,
    parameter int ROB_W   = 4,
    parameter logic [XLEN-1:0] MMIO_BASE = XLEN'(MMIO_BASE_DEFAULT)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       rdy,
    input  logic                       flush,
    input  logic                       stall,
    input  logic                       io_buffer_full,
    input  logic                       enq_valid,
    input  logic [INST_OP_WIDTH-1:0]   enq_op,
    input  logic [XLEN-1:0]            enq_imm,
    input  logic [ROB_W-1:0]           enq_id,
    input  logic [ROB_W:0]             enq_Q1,
    input  logic [XLEN-1:0]            enq_V1,
    input  logic [ROB_W:0]             enq_Q2,
    input  logic [XLEN-1:0]            enq_V2,
    input  logic [NUM_CDB-1:0]         cdb_valid,
    input  logic [NUM_CDB*ROB_W-1:0]   cdb_id,
    input  logic [NUM_CDB*XLEN-1:0]    cdb_val,
    input  logic [ROB_W-1:0]           rob_head_id,
    input  logic                       rob_store_commit,
    input  logic                       mem_busy,
    output logic                       lsq_full,
    output logic                       lsq_empty,
    output logic [$clog2(DEPTH):0]     lsq_count,
    output logic                       lsq_front_store_ready,
    output logic [ROB_W-1:0]           lsq_front_id,
    output logic                       lsq_mem_enable,
    output logic                       lsq_mem_is_store,
    output logic [INST_OP_WIDTH-1:0]   lsq_mem_op,
    output logic [XLEN-1:0]            lsq_mem_addr,
    output logic [XLEN-1:0]            lsq_mem_data,
    output logic [ROB_W-1:0]           lsq_mem_id,
    output logic                       lsq_fwd_valid,
    output logic [ROB_W-1:0]           lsq_fwd_id,
    output logic [XLEN-1:0]            lsq_fwd_data
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [ROB_W:0] DEP = '1;

    logic [DEPTH-1:0]                    r_busy, r_issued;
    logic [DEPTH-1:0][INST_OP_WIDTH-1:0] r_op;
    logic [DEPTH-1:0][ROB_W-1:0]         r_id;
    logic [DEPTH-1:0][ROB_W:0]           r_q1, r_q2;
    logic [DEPTH-1:0][XLEN-1:0]          r_a, r_d;
    logic [PTR_W-1:0]                    r_head, r_tail;
    logic [PTR_W:0]                      r_count;

    logic                     r_mem_en, r_mem_st, r_fwd_v;
    logic [INST_OP_WIDTH-1:0] r_mem_op;
    logic [XLEN-1:0]          r_mem_addr, r_mem_data, r_fwd_data;
    logic [ROB_W-1:0]         r_mem_id, r_fwd_id;

    // {hit, value}; iterating high to low lets the lowest bus index win.
    function automatic logic [XLEN:0] cdb_snoop(input logic [ROB_W:0] q);
        logic [XLEN:0] res;
        res = '0;
        for (int b = NUM_CDB-1; b >= 0; b--)
            if (cdb_valid[b] && q == {1'b0, cdb_id[b*ROB_W +: ROB_W]})
                res = {1'b1, cdb_val[b*XLEN +: XLEN]};
        return res;
    endfunction

    logic [DEPTH-1:0][XLEN:0]       w_snp1, w_snp2;
    logic [XLEN:0]                  w_esnp1, w_esnp2;
    logic [ROB_W:0]                 w_enq_q1, w_enq_q2;
    logic [XLEN-1:0]                w_enq_a, w_enq_d;
    logic [DEPTH-1:0][PTR_W-1:0]    w_rel;
    logic [DEPTH-1:0]               w_st, w_unres, w_blk_addr;
    logic [DEPTH-1:0][DEPTH-1:0]    w_older_st, w_ovl;
    logic [DEPTH-1:0]               w_ovl_any, w_fwd, w_elig;
    logic [DEPTH-1:0][PTR_W-1:0]    w_ys_idx;
    logic                           w_ld_v, w_front_st_rdy, w_enq, w_retire;
    logic [PTR_W-1:0]               w_ld_idx;
    lsq_act_e                       w_act;

    always_comb begin
        w_esnp1 = cdb_snoop(enq_Q1);
        w_esnp2 = cdb_snoop(enq_Q2);
        for (int i = 0; i < DEPTH; i++) begin
            w_snp1[i] = cdb_snoop(r_q1[i]);
            w_snp2[i] = cdb_snoop(r_q2[i]);
        end
        w_enq_q1 = enq_Q1;
        w_enq_a  = enq_imm;
        if (enq_Q1 == DEP) begin
            w_enq_a = enq_V1 + enq_imm;
        end else if (w_esnp1[XLEN]) begin
            w_enq_q1 = DEP;
            w_enq_a  = w_esnp1[XLEN-1:0] + enq_imm;
        end
        w_enq_q2 = DEP;
        w_enq_d  = '0;
        if (op_is_store(enq_op)) begin
            if (enq_Q2 == DEP)       w_enq_d = enq_V2;
            else if (w_esnp2[XLEN])  w_enq_d = w_esnp2[XLEN-1:0];
            else                     w_enq_q2 = enq_Q2;
        end
    end

    // Age is the distance from head; smaller is older.
    always_comb begin
        w_older_st = '0;
        w_ovl      = '0;
        w_blk_addr = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_rel[i]  = PTR_W'(i) - r_head;
            w_st[i]   = r_busy[i] && op_is_store(r_op[i]);
            w_unres[i] = r_q1[i] != DEP;
        end
        for (int i = 0; i < DEPTH; i++) begin
            for (int j = 0; j < DEPTH; j++) begin
                w_older_st[i][j] = w_st[j] && (w_rel[j] < w_rel[i]);
                w_ovl[i][j] = w_older_st[i][j] && !w_unres[j]
                              && r_a[j][XLEN-1:2] == r_a[i][XLEN-1:2];
            end
            w_blk_addr[i] = |(w_older_st[i] & w_unres);
        end
    end

    // Youngest older overlapping store: scan downward from the load by
    // reversing the mask and starting the picker just below it.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ys
        logic [DEPTH-1:0] w_rev;
        logic [PTR_W-1:0] w_k;
        always_comb
            for (int k = 0; k < DEPTH; k++) w_rev[k] = w_ovl[gi][DEPTH-1-k];
        lsq_oldest_picker #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_ys (
            .i_req   (w_rev),
            .i_head  (PTR_W'((DEPTH - gi) % DEPTH)),
            .o_valid (w_ovl_any[gi]),
            .o_idx   (w_k)
        );
        assign w_ys_idx[gi] = PTR_W'(DEPTH-1) - w_k;
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_fwd[i] = w_ovl_any[i] && r_op[w_ys_idx[i]] == OP_SW
                       && r_q2[w_ys_idx[i]] == DEP && r_op[i] == OP_LW
                       && r_a[w_ys_idx[i]] == r_a[i];
            w_elig[i] = r_busy[i] && !op_is_store(r_op[i]) && !r_issued[i]
                        && !w_unres[i] && !w_blk_addr[i]
                        && (!w_ovl_any[i] || w_fwd[i])
                        && (r_a[i] < MMIO_BASE
                            || (r_id[i] == rob_head_id && !io_buffer_full && !w_fwd[i]));
        end
    end

    lsq_oldest_picker #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_ld_pick (
        .i_req   (w_elig),
        .i_head  (r_head),
        .o_valid (w_ld_v),
        .o_idx   (w_ld_idx)
    );

    assign w_front_st_rdy = w_st[r_head] && !w_unres[r_head] && r_q2[r_head] == DEP;

    always_comb begin
        w_act = ACT_NONE;
        if (!flush) begin
            if (w_front_st_rdy && rob_store_commit && !mem_busy) w_act = ACT_STORE;
            else if (w_ld_v && w_fwd[w_ld_idx])                  w_act = ACT_FWD;
            else if (w_ld_v && !mem_busy)                        w_act = ACT_LOAD;
        end
    end

    assign w_enq    = !flush && enq_valid && !stall && !lsq_full;
    assign w_retire = !flush && r_busy[r_head]
                      && (w_act == ACT_STORE || (!op_is_store(r_op[r_head]) && r_issued[r_head]));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy <= '0;  r_issued <= '0;  r_op <= '0;  r_id <= '0;
            r_q1 <= '0;    r_q2 <= '0;      r_a <= '0;   r_d <= '0;
            r_head <= '0;  r_tail <= '0;    r_count <= '0;
            r_mem_en <= 1'b0;  r_mem_st <= 1'b0;  r_mem_op <= '0;
            r_mem_addr <= '0;  r_mem_data <= '0;  r_mem_id <= '0;
            r_fwd_v <= 1'b0;   r_fwd_id <= '0;    r_fwd_data <= '0;
        end else if (rdy) begin
            r_mem_en <= (w_act == ACT_STORE) || (w_act == ACT_LOAD);
            r_fwd_v  <= (w_act == ACT_FWD);
            if (w_act == ACT_STORE) begin
                r_mem_st <= 1'b1;  r_mem_op <= r_op[r_head];  r_mem_addr <= r_a[r_head];
                r_mem_data <= r_d[r_head];  r_mem_id <= r_id[r_head];
            end else if (w_act == ACT_LOAD) begin
                r_mem_st <= 1'b0;  r_mem_op <= r_op[w_ld_idx];  r_mem_addr <= r_a[w_ld_idx];
                r_mem_data <= '0;  r_mem_id <= r_id[w_ld_idx];
            end
            if (w_act == ACT_FWD) begin
                r_fwd_id   <= r_id[w_ld_idx];
                r_fwd_data <= r_d[w_ys_idx[w_ld_idx]];
            end
            for (int i = 0; i < DEPTH; i++) begin
                if (r_busy[i] && w_snp1[i][XLEN]) begin
                    r_q1[i] <= DEP;
                    r_a[i]  <= r_a[i] + w_snp1[i][XLEN-1:0];
                end
                if (r_busy[i] && w_snp2[i][XLEN]) begin
                    r_q2[i] <= DEP;
                    r_d[i]  <= w_snp2[i][XLEN-1:0];
                end
            end
            if (w_act == ACT_LOAD || w_act == ACT_FWD) r_issued[w_ld_idx] <= 1'b1;
            if (w_retire) begin
                r_busy[r_head]   <= 1'b0;
                r_issued[r_head] <= 1'b0;
                r_head           <= r_head + 1'b1;
            end
            if (w_enq) begin
                r_busy[r_tail] <= 1'b1;   r_issued[r_tail] <= 1'b0;
                r_op[r_tail]   <= enq_op; r_id[r_tail]     <= enq_id;
                r_q1[r_tail]   <= w_enq_q1; r_a[r_tail]    <= w_enq_a;
                r_q2[r_tail]   <= w_enq_q2; r_d[r_tail]    <= w_enq_d;
                r_tail         <= r_tail + 1'b1;
            end
            if (flush) begin
                r_busy   <= '0;
                r_issued <= '0;
                r_tail   <= r_head;
                r_count  <= '0;
            end else begin
                r_count <= r_count + (PTR_W+1)'(w_enq) - (PTR_W+1)'(w_retire);
            end
        end
    end

    assign lsq_full              = r_count == (PTR_W+1)'(DEPTH);
    assign lsq_empty             = r_count == '0;
    assign lsq_count             = r_count;
    assign lsq_front_store_ready = w_front_st_rdy;
    assign lsq_front_id          = r_id[r_head];
    assign lsq_mem_enable        = r_mem_en;
    assign lsq_mem_is_store      = r_mem_st;
    assign lsq_mem_op            = r_mem_op;
    assign lsq_mem_addr          = r_mem_addr;
    assign lsq_mem_data          = r_mem_data;
    assign lsq_mem_id            = r_mem_id;
    assign lsq_fwd_valid         = r_fwd_v;
    assign lsq_fwd_id            = r_fwd_id;
    assign lsq_fwd_data          = r_fwd_data;

endmodule
